// File: rtl/regfile_sb_if.sv
// Decode/execute-side signal bundle for regfile_sb.
// The master modport is the decoder/load-unit side; the slave modport is the register file.
interface regfile_sb_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    logic [AW-1:0]          rs0;
    logic [AW-1:0]          rs1;
    logic [AW-1:0]          rd;
    logic                   r_latch;
    logic [WIDTH-1:0]       busD_in;
    logic [AW-1:0]          wb_addr;
    logic                   wb_en;
    logic [WIDTH-1:0]       wb_data;
    logic                   lock_en;
    logic [AW-1:0]          lock_addr;
    logic [WIDTH-1:0]       bus0;
    logic [WIDTH-1:0]       bus1;
    logic [WIDTH-1:0]       busD_out;
    logic                   busy0;
    logic                   busy1;
    logic                   busyD;
    logic                   lock_err;
    logic [NREGS*WIDTH-1:0] regs_flat;

    modport master (
        output rs0, rs1, rd, r_latch, busD_in, wb_addr, wb_en, wb_data, lock_en, lock_addr,
        input  bus0, bus1, busD_out, busy0, busy1, busyD, lock_err, regs_flat
    );

    modport slave (
        input  rs0, rs1, rd, r_latch, busD_in, wb_addr, wb_en, wb_data, lock_en, lock_addr,
        output bus0, bus1, busD_out, busy0, busy1, busyD, lock_err, regs_flat
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with 3 combinational read ports, write ports D and W (late load results),
// and a per-register busy scoreboard for decode stalls.
module regfile_sb #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 8,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  rf
);
    logic [WIDTH-1:0] regs_reg [NREGS];
    logic             busy_reg [NREGS];
    logic             lock_err_reg;
    logic             lock_err_next;

    logic             we_d;
    logic             we_w;
    logic             lock_ok;

    logic [AW-1:0]    rd_addr [3];
    logic [WIDTH-1:0] rd_data [3];
    logic             rd_busy [3];

    // With a hardwired R0, every write/lock aimed at address 0 is dropped up front.
    always_comb begin
        we_d    = rf.r_latch;
        we_w    = rf.wb_en;
        lock_ok = rf.lock_en;
        if (ZERO_R0 != 0) begin
            if (rf.rd == '0)        we_d    = 1'b0;
            if (rf.wb_addr == '0)   we_w    = 1'b0;
            if (rf.lock_addr == '0) lock_ok = 1'b0;
        end
    end

    // A same-cycle clear of the locked address means the earlier load is retiring: not an error.
    always_comb begin
        lock_err_next = lock_ok && busy_reg[rf.lock_addr]
                        && !(rf.wb_en && (rf.wb_addr == rf.lock_addr));
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            // Port D has priority over port W on a write collision.
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_reg[gi] <= '0;
                end else if (we_d && (rf.rd == AW'(gi))) begin
                    regs_reg[gi] <= rf.busD_in;
                end else if (we_w && (rf.wb_addr == AW'(gi))) begin
                    regs_reg[gi] <= rf.wb_data;
                end
            end

            // Lock beats clear so back-to-back loads to one register keep it busy.
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (lock_ok && (rf.lock_addr == AW'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (rf.wb_en && (rf.wb_addr == AW'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end

            assign rf.regs_flat[gi*WIDTH +: WIDTH] = regs_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_err_reg <= 1'b0;
        end else begin
            lock_err_reg <= lock_err_next;
        end
    end

    assign rd_addr[0] = rf.rs0;
    assign rd_addr[1] = rf.rs1;
    assign rd_addr[2] = rf.rd;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_rport
            assign rd_data[gi] =
                ((ZERO_R0 != 0) && (rd_addr[gi] == '0))                ? '0         :
                ((BYPASS != 0) && we_d && (rf.rd == rd_addr[gi]))      ? rf.busD_in :
                ((BYPASS != 0) && we_w && (rf.wb_addr == rd_addr[gi])) ? rf.wb_data :
                                                                         regs_reg[rd_addr[gi]];
            assign rd_busy[gi] = busy_reg[rd_addr[gi]];
        end
    endgenerate

    assign rf.bus0     = rd_data[0];
    assign rf.bus1     = rd_data[1];
    assign rf.busD_out = rd_data[2];
    assign rf.busy0    = rd_busy[0];
    assign rf.busy1    = rd_busy[1];
    assign rf.busyD    = rd_busy[2];
    assign rf.lock_err = lock_err_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: three regfile_sb instances (bypass, no-bypass, zero-R0) share one stimulus.
module tb_regfile_sb;
    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic clk;
    logic rst;

    logic [AW-1:0]    rs0, rs1, rd, wb_addr, lock_addr;
    logic             r_latch, wb_en, lock_en;
    logic [WIDTH-1:0] busD_in, wb_data;

    int checks = 0;
    int errors = 0;

    regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) ifa ();
    regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) ifn ();
    regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) ifz ();

    assign ifa.rs0 = rs0;         assign ifn.rs0 = rs0;         assign ifz.rs0 = rs0;
    assign ifa.rs1 = rs1;         assign ifn.rs1 = rs1;         assign ifz.rs1 = rs1;
    assign ifa.rd = rd;           assign ifn.rd = rd;           assign ifz.rd = rd;
    assign ifa.r_latch = r_latch; assign ifn.r_latch = r_latch; assign ifz.r_latch = r_latch;
    assign ifa.busD_in = busD_in; assign ifn.busD_in = busD_in; assign ifz.busD_in = busD_in;
    assign ifa.wb_addr = wb_addr; assign ifn.wb_addr = wb_addr; assign ifz.wb_addr = wb_addr;
    assign ifa.wb_en = wb_en;     assign ifn.wb_en = wb_en;     assign ifz.wb_en = wb_en;
    assign ifa.wb_data = wb_data; assign ifn.wb_data = wb_data; assign ifz.wb_data = wb_data;
    assign ifa.lock_en = lock_en; assign ifn.lock_en = lock_en; assign ifz.lock_en = lock_en;
    assign ifa.lock_addr = lock_addr; assign ifn.lock_addr = lock_addr; assign ifz.lock_addr = lock_addr;

    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .rf(ifa)
    );
    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .BYPASS(0), .ZERO_R0(0)) dut_n (
        .clk(clk), .rst(rst), .rf(ifn)
    );
    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .BYPASS(1), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .rf(ifz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_latch = 1'b0;
        wb_en   = 1'b0;
        lock_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rs0 = '0; rs1 = '0; rd = '0; wb_addr = '0; lock_addr = '0;
        busD_in = '0; wb_data = '0;
        idle();
        tick();
        rst = 1'b0;

        // Reset: preload some state, then reset with writes/locks pending
        r_latch = 1'b1; rd = 3'd1; busD_in = 16'h1234;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h5678;
        lock_en = 1'b1; lock_addr = 3'd7;
        tick();
        idle(); rs0 = 3'd7;
        #1;
        chk("pre_r1", ifa.regs_flat[1*WIDTH +: WIDTH], 16'h1234);
        chk("pre_r6", ifa.regs_flat[6*WIDTH +: WIDTH], 16'h5678);
        chk("pre_busy7", ifa.busy0, 1'b1);
        rst = 1'b1;
        r_latch = 1'b1; rd = 3'd2; busD_in = 16'hAAAA;
        lock_en = 1'b1; lock_addr = 3'd3;
        tick();
        rst = 1'b0; idle(); rs0 = 3'd7; rs1 = 3'd3; rd = 3'd2;
        #1;
        chk("rst_flat_a", ifa.regs_flat, 128'h0);
        chk("rst_flat_n", ifn.regs_flat, 128'h0);
        chk("rst_flat_z", ifz.regs_flat, 128'h0);
        chk("rst_busy0", ifa.busy0, 1'b0);
        chk("rst_busy1", ifa.busy1, 1'b0);
        chk("rst_busyD", ifa.busyD, 1'b0);
        chk("rst_lockerr", ifa.lock_err, 1'b0);

        // Bypass: D write to 3 and W write to 4 seen same cycle only with BYPASS=1
        rs0 = 3'd3; rs1 = 3'd4; rd = 3'd3;
        r_latch = 1'b1; busD_in = 16'hBEEF;
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'hCAFE;
        #1;
        chk("byp_bus0", ifa.bus0, 16'hBEEF);
        chk("byp_busD", ifa.busD_out, 16'hBEEF);
        chk("byp_bus1", ifa.bus1, 16'hCAFE);
        chk("byp_flat3", ifa.regs_flat[3*WIDTH +: WIDTH], 16'h0000);
        chk("nobyp_bus0", ifn.bus0, 16'h0000);
        chk("nobyp_bus1", ifn.bus1, 16'h0000);
        tick();
        idle();
        #1;
        chk("byp_r3", ifa.regs_flat[3*WIDTH +: WIDTH], 16'hBEEF);
        chk("nobyp_bus0_2", ifn.bus0, 16'hBEEF);
        chk("nobyp_bus1_2", ifn.bus1, 16'hCAFE);

        // Collision on 5 while 5 is busy: D data stored, busy cleared
        lock_en = 1'b1; lock_addr = 3'd5;
        tick();
        idle(); rs1 = 3'd5;
        #1;
        chk("col_busy_pre", ifa.busy1, 1'b1);
        r_latch = 1'b1; rd = 3'd5; busD_in = 16'h1111;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h2222;
        #1;
        chk("col_bus1", ifa.bus1, 16'h1111);
        chk("col_nb_bus1", ifn.bus1, 16'h0000);
        chk("col_busy_hold", ifa.busy1, 1'b1);
        tick();
        idle();
        #1;
        chk("col_r5", ifa.regs_flat[5*WIDTH +: WIDTH], 16'h1111);
        chk("col_busy_post", ifa.busy1, 1'b0);
        chk("col_nb_post", ifn.bus1, 16'h1111);

        // Scoreboard: lock 2, lock+clear 2 together, then clear alone
        lock_en = 1'b1; lock_addr = 3'd2;
        tick();
        idle(); rs1 = 3'd2;
        #1;
        chk("sb_busy_set", ifa.busy1, 1'b1);
        lock_en = 1'b1; lock_addr = 3'd2;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0042;
        tick();
        idle();
        #1;
        chk("sb_lock_wins", ifa.busy1, 1'b1);
        chk("sb_no_err", ifa.lock_err, 1'b0);
        chk("sb_r2", ifa.regs_flat[2*WIDTH +: WIDTH], 16'h0042);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0043;
        tick();
        idle();
        #1;
        chk("sb_cleared", ifa.busy1, 1'b0);
        chk("sb_r2b", ifa.bus1, 16'h0043);

        // lock_err: lock 4 on two consecutive edges
        lock_en = 1'b1; lock_addr = 3'd4; rs0 = 3'd4;
        tick();
        #1;
        chk("le_first", ifa.lock_err, 1'b0);
        tick();
        idle();
        #1;
        chk("le_pulse", ifa.lock_err, 1'b1);
        chk("le_busy", ifa.busy0, 1'b1);
        tick();
        chk("le_drop", ifa.lock_err, 1'b0);
        chk("le_busy_hold", ifa.busy0, 1'b1);
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0004;
        tick();
        idle();
        #1;
        chk("le_release", ifa.busy0, 1'b0);

        // Zero R0: writes and repeated locks to 0 have no effect on dut_z
        rs0 = 3'd0;
        r_latch = 1'b1; rd = 3'd0; busD_in = 16'hFFFF;
        lock_en = 1'b1; lock_addr = 3'd0;
        #1;
        chk("z_bus0_comb", ifz.bus0, 16'h0000);
        chk("a_bus0_comb", ifa.bus0, 16'hFFFF);
        tick();
        r_latch = 1'b0;
        #1;
        chk("z_bus0", ifz.bus0, 16'h0000);
        chk("z_busy0", ifz.busy0, 1'b0);
        chk("a_busy0", ifa.busy0, 1'b1);
        tick();
        idle();
        #1;
        chk("z_flat0", ifz.regs_flat[0 +: WIDTH], 16'h0000);
        chk("z_lockerr", ifz.lock_err, 1'b0);
        chk("a_lockerr", ifa.lock_err, 1'b1);
        chk("a_r0", ifa.regs_flat[0 +: WIDTH], 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
